// File: rtl/mem_arbiter_if.sv
// ============================================================================
// Module : mem_arbiter_if
// Fetch/data requester ports and RAM-side port shared by mem_arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface mem_arbiter_if #(
  parameter int MEM_AW = 10
);
  logic              i_req;
  logic [31:0]       i_addr;
  logic [31:0]       i_rdata;
  logic              i_ack;
  logic              d_req;
  logic [3:0]        d_we;
  logic [31:0]       d_addr;
  logic [31:0]       d_wdata;
  logic [31:0]       d_rdata;
  logic              d_ack;
  logic              mem_en;
  logic [3:0]        mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  // Arbiter side: accepts requests, drives acks and the RAM strobes.
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_rdata, i_ack, d_rdata, d_ack, mem_en, mem_we, mem_addr, mem_wdata
  );

  // Environment side: requesters plus RAM.
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_rdata, i_ack, d_rdata, d_ack, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module : mem_arbiter
// Shares one 1-cycle-latency RAM between fetch and data ports, data priority.
// Optional wait counters enabled by defining ARB_PERF_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mem_arbiter #(
  parameter int MEM_AW = 10
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  mem_arbiter_if.slave  bus
`ifdef ARB_PERF_EN
  ,
  output logic [31:0]   perf_i_wait,
  output logic [31:0]   perf_d_wait
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RESP_I = 2'd1,
    RESP_D = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;
  logic   w_i_elig;
  logic   w_d_elig;
  logic   w_grant_i;
  logic   w_grant_d;

  // A port's held req is ignored during its own ack cycle.
  assign w_i_elig  = bus.i_req && (r_state != RESP_I);
  assign w_d_elig  = bus.d_req && (r_state != RESP_D);
  assign w_grant_d = w_d_elig;
  assign w_grant_i = w_i_elig && !w_d_elig;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state  = IDLE;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 4'b0000;
    bus.mem_addr  = '0;
    bus.mem_wdata = 32'd0;
    if (w_grant_d) begin
      w_next_state  = RESP_D;
      bus.mem_en    = 1'b1;
      bus.mem_we    = bus.d_we;
      bus.mem_addr  = bus.d_addr[MEM_AW+1:2];
      bus.mem_wdata = bus.d_wdata;
    end else if (w_grant_i) begin
      w_next_state  = RESP_I;
      bus.mem_en    = 1'b1;
      bus.mem_addr  = bus.i_addr[MEM_AW+1:2];
    end
  end

  assign bus.i_ack   = (r_state == RESP_I);
  assign bus.d_ack   = (r_state == RESP_D);
  assign bus.i_rdata = bus.i_ack ? bus.mem_rdata : 32'd0;
  assign bus.d_rdata = bus.d_ack ? bus.mem_rdata : 32'd0;

  // Byte-offset and out-of-range address bits are discarded by design.
  logic w_unused;
  assign w_unused = ^{bus.i_addr[31:MEM_AW+2], bus.i_addr[1:0],
                      bus.d_addr[31:MEM_AW+2], bus.d_addr[1:0]};

`ifdef ARB_PERF_EN
  logic [31:0] r_perf_i;
  logic [31:0] r_perf_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_i <= 32'd0;
      r_perf_d <= 32'd0;
    end else begin
      if (w_i_elig && !w_grant_i) r_perf_i <= r_perf_i + 32'd1;
      if (w_d_elig && !w_grant_d) r_perf_d <= r_perf_d + 32'd1;
    end
  end

  assign perf_i_wait = r_perf_i;
  assign perf_d_wait = r_perf_d;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module : tb_mem_arbiter
// Self-checking bench for mem_arbiter with a behavioural RAM and ack scoreboard.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

  typedef struct packed {
    logic        is_d;
    logic        chk;
    logic [31:0] data;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  mem_arbiter_if #(.MEM_AW(10)) bus ();

`ifdef ARB_PERF_EN
  logic [31:0] perf_i_wait;
  logic [31:0] perf_d_wait;
`endif

  mem_arbiter #(.MEM_AW(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef ARB_PERF_EN
    ,
    .perf_i_wait (perf_i_wait),
    .perf_d_wait (perf_d_wait)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: read-first, byte writes committed at the issue edge.
  logic [31:0] ram [0:1023];
  logic [31:0] ram_q;
  logic        pl_en;
  logic [9:0]  pl_addr;
  logic [31:0] pl_data;

  always @(posedge clk) begin
    if (pl_en) begin
      ram[pl_addr] <= pl_data;
    end else if (bus.mem_en) begin
      ram_q <= ram[bus.mem_addr];
      for (int b = 0; b < 4; b++)
        if (bus.mem_we[b]) ram[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
    end
  end
  assign bus.mem_rdata = ram_q;

  function automatic exp_t mk(input logic is_d, input logic chk, input logic [31:0] data);
    exp_t e;
    e.is_d = is_d; e.chk = chk; e.data = data;
    return e;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [9:0] a, input logic [31:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    bus.i_req = 1'b0; bus.i_addr = '0; bus.d_req = 1'b0; bus.d_we = '0;
    bus.d_addr = '0; bus.d_wdata = '0;
    preload(10'd4, 32'hDEADBEEF);
    preload(10'd8, 32'hA5A5A5A5);
    @(negedge clk);
    n_checks++; if (bus.i_ack !== 1'b0) begin n_fail++; $display("FAIL reset_i_ack: got %0h expected 0", bus.i_ack); end
    n_checks++; if (bus.d_ack !== 1'b0) begin n_fail++; $display("FAIL reset_d_ack: got %0h expected 0", bus.d_ack); end
    n_checks++; if ({bus.mem_en, bus.mem_we, bus.mem_addr} !== 15'd0) begin n_fail++; $display("FAIL reset_mem_idle: got en=%0h we=%0h addr=%0h expected all 0", bus.mem_en, bus.mem_we, bus.mem_addr); end
    n_checks++; if ({bus.i_rdata, bus.d_rdata} !== 64'd0) begin n_fail++; $display("FAIL reset_rdata: got i=%0h d=%0h expected 0", bus.i_rdata, bus.d_rdata); end
    // Request logic is not gated by reset.
    bus.d_req = 1'b1; bus.d_addr = 32'h20;
    #1;
    n_checks++; if (bus.mem_en !== 1'b1 || bus.mem_addr !== 10'd8) begin n_fail++; $display("FAIL reset_comb_grant: got en=%0h addr=%0h expected en=1 addr=8", bus.mem_en, bus.mem_addr); end
    bus.d_req = 1'b0;
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_fetch();
    logic [2:0] en_pat;
    logic [2:0] ack_pat;
    exp_t e;
    en_pat = 3'b001; ack_pat = 3'b010;
    bus.i_req = 1'b1; bus.i_addr = 32'h10;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) bus.i_req = 1'b0;
      if (en_pat[c]) sb.push_back(mk(1'b0, 1'b1, 32'hDEADBEEF));
      @(negedge clk);
      n_checks++; if (bus.mem_en !== en_pat[c]) begin n_fail++; $display("FAIL fetch_en c%0d: got %0h expected %0h", c, bus.mem_en, en_pat[c]); end
      if (en_pat[c]) begin
        n_checks++; if (bus.mem_addr !== 10'd4 || bus.mem_we !== 4'd0 || bus.mem_wdata !== 32'd0) begin n_fail++; $display("FAIL fetch_bus c%0d: got addr=%0h we=%0h wdata=%0h expected 4/0/0", c, bus.mem_addr, bus.mem_we, bus.mem_wdata); end
      end
      n_checks++; if (bus.i_ack !== ack_pat[c]) begin n_fail++; $display("FAIL fetch_ack c%0d: got %0h expected %0h", c, bus.i_ack, ack_pat[c]); end
      if (bus.i_ack || bus.d_ack) begin
        n_checks++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL fetch_sb c%0d: got unexpected ack i=%0h d=%0h expected none", c, bus.i_ack, bus.d_ack); end
        else begin
          e = sb.pop_front();
          if (bus.d_ack !== e.is_d || bus.i_rdata !== e.data) begin n_fail++; $display("FAIL fetch_sb c%0d: got d_ack=%0h rdata=%0h expected d_ack=%0h rdata=%0h", c, bus.d_ack, bus.i_rdata, e.is_d, e.data); end
        end
      end
      next_cycle();
    end
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL fetch_leftover: got %0d pending expected 0", sb.size()); end
    sb.delete();
  endtask

  task automatic test_write();
    logic [6:0] en_pat;
    exp_t e;
    en_pat = 7'b0010101;
    bus.d_req = 1'b1; bus.d_we = 4'b0011; bus.d_addr = 32'h20; bus.d_wdata = 32'h0000_1234;
    for (int c = 0; c < 7; c++) begin
      case (c)
        2: bus.d_we = 4'b0000;
        3: bus.d_addr = 32'hFFFF_F020;
        5: bus.d_req = 1'b0;
        default: ;
      endcase
      if (en_pat[c]) sb.push_back(mk(1'b1, c != 0, 32'hA5A5_1234));
      @(negedge clk);
      n_checks++; if (bus.mem_en !== en_pat[c]) begin n_fail++; $display("FAIL write_en c%0d: got %0h expected %0h", c, bus.mem_en, en_pat[c]); end
      if (en_pat[c]) begin
        n_checks++;
        if (bus.mem_addr !== 10'd8 || bus.mem_we !== ((c == 0) ? 4'b0011 : 4'b0000) || bus.mem_wdata !== 32'h1234) begin
          n_fail++; $display("FAIL write_bus c%0d: got addr=%0h we=%0h wdata=%0h expected addr=8 we=%0h wdata=1234", c, bus.mem_addr, bus.mem_we, bus.mem_wdata, (c == 0) ? 4'b0011 : 4'b0000);
        end
      end
      if (bus.i_ack || bus.d_ack) begin
        n_checks++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL write_sb c%0d: got unexpected ack i=%0h d=%0h expected none", c, bus.i_ack, bus.d_ack); end
        else begin
          e = sb.pop_front();
          if (bus.d_ack !== e.is_d || (e.chk && bus.d_rdata !== e.data)) begin n_fail++; $display("FAIL write_sb c%0d: got d_ack=%0h rdata=%0h expected d_ack=%0h rdata=%0h", c, bus.d_ack, bus.d_rdata, e.is_d, e.data); end
        end
      end
      next_cycle();
    end
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL write_leftover: got %0d pending expected 0", sb.size()); end
    sb.delete();
    bus.d_addr = 32'h20;
  endtask

  task automatic test_contend();
    logic [4:0] en_pat;
    logic [4:0] gnt_d;
    exp_t e;
    en_pat = 5'b01111; gnt_d = 5'b00101;
    bus.i_req = 1'b1; bus.i_addr = 32'h10;
    bus.d_req = 1'b1; bus.d_we = 4'b0000; bus.d_addr = 32'h20; bus.d_wdata = 32'h1234;
    for (int c = 0; c < 5; c++) begin
      if (c == 4) begin bus.i_req = 1'b0; bus.d_req = 1'b0; end
      if (en_pat[c]) sb.push_back(mk(gnt_d[c], 1'b1, gnt_d[c] ? 32'hA5A5_1234 : 32'hDEADBEEF));
      @(negedge clk);
      n_checks++; if (bus.mem_en !== en_pat[c]) begin n_fail++; $display("FAIL contend_en c%0d: got %0h expected %0h", c, bus.mem_en, en_pat[c]); end
      if (en_pat[c]) begin
        n_checks++;
        if (bus.mem_addr !== (gnt_d[c] ? 10'd8 : 10'd4) || bus.mem_wdata !== (gnt_d[c] ? 32'h1234 : 32'd0)) begin
          n_fail++; $display("FAIL contend_grant c%0d: got addr=%0h wdata=%0h expected addr=%0h wdata=%0h", c, bus.mem_addr, bus.mem_wdata, gnt_d[c] ? 10'd8 : 10'd4, gnt_d[c] ? 32'h1234 : 32'd0);
        end
      end
      if (bus.i_ack || bus.d_ack) begin
        n_checks++;
        if (sb.size() == 0 || (bus.i_ack && bus.d_ack)) begin n_fail++; $display("FAIL contend_sb c%0d: got ack i=%0h d=%0h expected one expected ack", c, bus.i_ack, bus.d_ack); end
        else begin
          e = sb.pop_front();
          if (bus.d_ack !== e.is_d || (bus.d_ack ? bus.d_rdata : bus.i_rdata) !== e.data) begin n_fail++; $display("FAIL contend_sb c%0d: got d_ack=%0h data=%0h expected d_ack=%0h data=%0h", c, bus.d_ack, bus.d_ack ? bus.d_rdata : bus.i_rdata, e.is_d, e.data); end
        end
      end
      next_cycle();
    end
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL contend_leftover: got %0d pending expected 0", sb.size()); end
    sb.delete();
  endtask

  task automatic test_single();
    logic [6:0] en_pat;
    logic [6:0] ack_pat;
    exp_t e;
    en_pat = 7'b0010101; ack_pat = 7'b0101010;
    bus.i_req = 1'b1; bus.i_addr = 32'h10;
    for (int c = 0; c < 7; c++) begin
      if (c == 6) bus.i_req = 1'b0;
      if (en_pat[c]) sb.push_back(mk(1'b0, 1'b1, 32'hDEADBEEF));
      @(negedge clk);
      n_checks++; if (bus.mem_en !== en_pat[c]) begin n_fail++; $display("FAIL single_en c%0d: got %0h expected %0h", c, bus.mem_en, en_pat[c]); end
      n_checks++; if (bus.i_ack !== ack_pat[c]) begin n_fail++; $display("FAIL single_ack c%0d: got %0h expected %0h", c, bus.i_ack, ack_pat[c]); end
      if (bus.i_ack) begin
        n_checks++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL single_sb c%0d: got unexpected ack expected none", c); end
        else begin
          e = sb.pop_front();
          if (bus.i_rdata !== e.data) begin n_fail++; $display("FAIL single_sb c%0d: got rdata=%0h expected %0h", c, bus.i_rdata, e.data); end
        end
      end
      next_cycle();
    end
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL single_leftover: got %0d pending expected 0", sb.size()); end
    sb.delete();
  endtask

  task automatic test_drop();
    bus.i_req = 1'b1; bus.i_addr = 32'h10; bus.d_req = 1'b1; bus.d_we = 4'b0000; bus.d_addr = 32'h20;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin bus.i_req = 1'b0; bus.d_req = 1'b0; end
      @(negedge clk);
      n_checks++; if (bus.mem_en !== (c == 0)) begin n_fail++; $display("FAIL drop_en c%0d: got %0h expected %0h", c, bus.mem_en, c == 0); end
      n_checks++; if (bus.d_ack !== (c == 1) || bus.i_ack !== 1'b0) begin n_fail++; $display("FAIL drop_ack c%0d: got d=%0h i=%0h expected d=%0h i=0", c, bus.d_ack, bus.i_ack, c == 1); end
      next_cycle();
    end
  endtask

  task automatic test_async_reset();
    bus.d_req = 1'b1; bus.d_we = 4'b0000; bus.d_addr = 32'h20;
    next_cycle();
    #1;
    n_checks++; if (bus.d_ack !== 1'b1 || bus.mem_en !== 1'b0) begin n_fail++; $display("FAIL arst_before: got d_ack=%0h en=%0h expected 1/0", bus.d_ack, bus.mem_en); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (bus.d_ack !== 1'b0) begin n_fail++; $display("FAIL arst_ack: got %0h expected 0", bus.d_ack); end
    // Held d_req becomes eligible again only if state left RESP_D.
    n_checks++; if (bus.mem_en !== 1'b1 || bus.mem_addr !== 10'd8) begin n_fail++; $display("FAIL arst_state: got en=%0h addr=%0h expected 1/8", bus.mem_en, bus.mem_addr); end
    #1 bus.d_req = 1'b0;
    #1 rst_n = 1'b1;
    next_cycle();
    bus.i_req = 1'b1; bus.i_addr = 32'h10;
    @(negedge clk);
    n_checks++; if (bus.mem_en !== 1'b1 || bus.mem_addr !== 10'd4) begin n_fail++; $display("FAIL arst_reissue: got en=%0h addr=%0h expected 1/4", bus.mem_en, bus.mem_addr); end
    next_cycle();
    bus.i_req = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.i_ack !== 1'b1 || bus.i_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL arst_reack: got ack=%0h rdata=%0h expected 1/deadbeef", bus.i_ack, bus.i_rdata); end
    next_cycle();
    @(negedge clk);
    n_checks++; if (bus.i_ack !== 1'b0 || bus.d_ack !== 1'b0) begin n_fail++; $display("FAIL arst_quiet: got i=%0h d=%0h expected 0/0", bus.i_ack, bus.d_ack); end
    next_cycle();
  endtask

`ifdef ARB_PERF_EN
  task automatic test_perf();
    rst_n = 1'b0;
    #2;
    n_checks++; if (perf_i_wait !== 32'd0 || perf_d_wait !== 32'd0) begin n_fail++; $display("FAIL perf_reset: got i=%0d d=%0d expected 0/0", perf_i_wait, perf_d_wait); end
    rst_n = 1'b1;
    next_cycle();
    bus.i_req = 1'b1; bus.i_addr = 32'h10; bus.d_req = 1'b1; bus.d_we = 4'b0000; bus.d_addr = 32'h20;
    for (int c = 0; c < 8; c++) next_cycle();
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    @(negedge clk);
    n_checks++; if (perf_i_wait !== 32'd1) begin n_fail++; $display("FAIL perf_i: got %0d expected 1", perf_i_wait); end
    n_checks++; if (perf_d_wait !== 32'd0) begin n_fail++; $display("FAIL perf_d: got %0d expected 0", perf_d_wait); end
    next_cycle();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fetch();
    test_write();
    test_contend();
    test_single();
    test_drop();
    test_async_reset();
`ifdef ARB_PERF_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
